// File: rtl/ps2_mouse_pkg.sv
// Shared states and constants for the PS/2 mouse tracker.
// No logic; types and localparams only.
// No flow control.
package ps2_mouse_pkg;

    typedef enum logic [2:0] {
        SEND_EN,
        WAIT_SENT,
        WAIT_ACK,
        BYTE0,
        BYTE1,
        BYTE2
    } mouse_state_t;

    localparam logic [7:0] CMD_ENABLE_REPORTING = 8'hF4;
    localparam logic [7:0] RESP_ACK             = 8'hFA;
    localparam logic [7:0] RESP_RESEND          = 8'hFE;
    localparam int         COORD_W              = 10;

endpackage

// File: rtl/mouse_axis_clamp.sv
// One cursor axis: applies a signed 9-bit delta (optionally doubled under MOUSE_ACCEL_EN), saturates to [0, limit-1].
// Latency: purely combinational.
// No flow control.
module mouse_axis_clamp
    import ps2_mouse_pkg::*;
(
    input  logic [COORD_W-1:0] cur,
    input  logic signed [8:0]  delta,
    input  logic               neg,
    input  logic [COORD_W-1:0] limit,
    output logic [COORD_W-1:0] nxt
);

`ifdef MOUSE_ACCEL_EN
    // Doubled deltas can reach 512 on top of a 639 position, so one extra bit.
    localparam int SUM_W = 12;
`else
    localparam int SUM_W = 11;
`endif

    logic signed [SUM_W-1:0] d_ext;
    logic signed [SUM_W-1:0] d_scl;
    logic signed [SUM_W-1:0] cur_ext;
    logic signed [SUM_W-1:0] lim_ext;
    logic signed [SUM_W-1:0] sum;

    always_comb begin
        d_ext   = {{(SUM_W-9){delta[8]}}, delta};
        cur_ext = {{(SUM_W-COORD_W){1'b0}}, cur};
        lim_ext = {{(SUM_W-COORD_W){1'b0}}, limit};
        d_scl   = d_ext;
`ifdef MOUSE_ACCEL_EN
        if ((d_ext >= 8) || (d_ext <= -8)) begin
            d_scl = d_ext <<< 1;
        end
`endif
        sum = neg ? (cur_ext - d_scl) : (cur_ext + d_scl);
        if (sum < 0) begin
            nxt = '0;
        end else if (sum >= lim_ext) begin
            nxt = limit - COORD_W'(1);
        end else begin
            nxt = sum[COORD_W-1:0];
        end
    end

endmodule

// File: rtl/ps2_mouse_tracker.sv
// Enables PS/2 mouse reporting, assembles 3-byte packets, tracks a clamped cursor (MOUSE_ACCEL_EN doubles large deltas).
// Latency: position/buttons/pkt_valid update on the edge after the third byte strobe.
// No backpressure: strobes are consumed every cycle; send_command is level-held until done or failed.
module ps2_mouse_tracker
    import ps2_mouse_pkg::*;
#(
    parameter int SCREEN_W    = 640,
    parameter int SCREEN_H    = 480,
    parameter int CURSOR_S    = 4,
    parameter int ACK_TIMEOUT = 5000000,
    parameter int PKT_TIMEOUT = 1000000
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic [7:0] received_data,
    input  logic       received_data_en,
    input  logic       command_was_sent,
    input  logic       error_communication_timed_out,
    output logic [7:0] the_command,
    output logic       send_command,
    output logic [9:0] MouseX,
    output logic [9:0] MouseY,
    output logic [9:0] MouseS,
    output logic       LeftBtn,
    output logic       RightBtn,
    output logic       pkt_valid,
    output logic       init_done
);

    localparam int CNT_MAX = (ACK_TIMEOUT > PKT_TIMEOUT) ? ACK_TIMEOUT : PKT_TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;
    localparam logic [CNT_W-1:0] ACK_LAST = CNT_W'(ACK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] PKT_LAST = CNT_W'(PKT_TIMEOUT - 1);

    mouse_state_t        state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [COORD_W-1:0]  x_q, x_d, y_q, y_d, x_nxt, y_nxt;
    logic [1:0]          btn_q, btn_d, btn_pend_q, btn_pend_d;
    logic [1:0]          ovf_q, ovf_d;
    logic                xs_q, xs_d, ys_q, ys_d;
    logic [7:0]          dx_lo_q, dx_lo_d;
    logic                pkt_valid_q, pkt_valid_d;
    logic                init_done_q, init_done_d;
    logic                send_cmd_q, send_cmd_d;

    // Y delta comes straight off the bus so the update lands one edge after the last strobe.
    mouse_axis_clamp u_clamp_x (
        .cur   (x_q),
        .delta ({xs_q, dx_lo_q}),
        .neg   (1'b0),
        .limit (COORD_W'(SCREEN_W)),
        .nxt   (x_nxt)
    );

    mouse_axis_clamp u_clamp_y (
        .cur   (y_q),
        .delta ({ys_q, received_data}),
        .neg   (1'b1),
        .limit (COORD_W'(SCREEN_H)),
        .nxt   (y_nxt)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        x_d         = x_q;
        y_d         = y_q;
        btn_d       = btn_q;
        btn_pend_d  = btn_pend_q;
        ovf_d       = ovf_q;
        xs_d        = xs_q;
        ys_d        = ys_q;
        dx_lo_d     = dx_lo_q;
        pkt_valid_d = 1'b0;
        init_done_d = init_done_q;
        send_cmd_d  = send_cmd_q;
        case (state_q)
            SEND_EN: begin
                send_cmd_d = 1'b1;
                cnt_d      = '0;
                state_d    = WAIT_SENT;
            end
            WAIT_SENT: begin
                if (command_was_sent) begin
                    send_cmd_d = 1'b0;
                    cnt_d      = '0;
                    state_d    = WAIT_ACK;
                end else if (error_communication_timed_out) begin
                    send_cmd_d = 1'b0;
                    state_d    = SEND_EN;
                end
            end
            WAIT_ACK: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (received_data_en) begin
                    if (received_data == RESP_ACK) begin
                        init_done_d = 1'b1;
                        cnt_d       = '0;
                        state_d     = BYTE0;
                    end
                end else if (cnt_q >= ACK_LAST) begin
                    state_d = SEND_EN;
                end
            end
            BYTE0: begin
                cnt_d = '0;
                if (received_data_en && received_data[3]) begin
                    btn_pend_d = received_data[1:0];
                    xs_d       = received_data[4];
                    ys_d       = received_data[5];
                    ovf_d      = received_data[7:6];
                    state_d    = BYTE1;
                end
            end
            BYTE1: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (received_data_en) begin
                    dx_lo_d = received_data;
                    cnt_d   = '0;
                    state_d = BYTE2;
                end else if (cnt_q >= PKT_LAST) begin
                    cnt_d   = '0;
                    state_d = BYTE0;
                end
            end
            BYTE2: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (received_data_en) begin
                    if (ovf_q == 2'b00) begin
                        x_d = x_nxt;
                        y_d = y_nxt;
                    end
                    btn_d       = btn_pend_q;
                    pkt_valid_d = 1'b1;
                    cnt_d       = '0;
                    state_d     = BYTE0;
                end else if (cnt_q >= PKT_LAST) begin
                    cnt_d   = '0;
                    state_d = BYTE0;
                end
            end
            default: state_d = SEND_EN;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= SEND_EN;
            cnt_q       <= '0;
            x_q         <= COORD_W'(SCREEN_W / 2);
            y_q         <= COORD_W'(SCREEN_H / 2);
            btn_q       <= 2'b00;
            btn_pend_q  <= 2'b00;
            ovf_q       <= 2'b00;
            xs_q        <= 1'b0;
            ys_q        <= 1'b0;
            dx_lo_q     <= 8'h00;
            pkt_valid_q <= 1'b0;
            init_done_q <= 1'b0;
            send_cmd_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            x_q         <= x_d;
            y_q         <= y_d;
            btn_q       <= btn_d;
            btn_pend_q  <= btn_pend_d;
            ovf_q       <= ovf_d;
            xs_q        <= xs_d;
            ys_q        <= ys_d;
            dx_lo_q     <= dx_lo_d;
            pkt_valid_q <= pkt_valid_d;
            init_done_q <= init_done_d;
            send_cmd_q  <= send_cmd_d;
        end
    end

    assign the_command  = CMD_ENABLE_REPORTING;
    assign send_command = send_cmd_q;
    assign MouseX       = x_q;
    assign MouseY       = y_q;
    assign MouseS       = COORD_W'(CURSOR_S);
    assign LeftBtn      = btn_q[0];
    assign RightBtn     = btn_q[1];
    assign pkt_valid    = pkt_valid_q;
    assign init_done    = init_done_q;

endmodule

// File: tb/tb_ps2_mouse_tracker.sv
// Bench for ps2_mouse_tracker: command handshake, packet assembly, clamping, resync and timeouts.
// Expected cursor state comes from an integer model pushed to a scoreboard queue per packet.
module tb_ps2_mouse_tracker;

    localparam int ACK_TO = 200;
    localparam int PKT_TO = 100;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       l;
        logic       r;
    } exp_t;

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic [7:0] received_data = 8'h00;
    logic       received_data_en = 1'b0;
    logic       command_was_sent = 1'b0;
    logic       error_communication_timed_out = 1'b0;
    logic [7:0] the_command;
    logic       send_command;
    logic [9:0] MouseX, MouseY, MouseS;
    logic       LeftBtn, RightBtn, pkt_valid, init_done;

    int   errors = 0;
    int   checks = 0;
    int   pushed = 0;
    int   pulses = 0;
    int   mx = 320;
    int   my = 240;
    exp_t sb[$];

    ps2_mouse_tracker #(
        .SCREEN_W   (640),
        .SCREEN_H   (480),
        .CURSOR_S   (4),
        .ACK_TIMEOUT(ACK_TO),
        .PKT_TIMEOUT(PKT_TO)
    ) dut (
        .Clk                          (Clk),
        .Reset_n                      (Reset_n),
        .received_data                (received_data),
        .received_data_en             (received_data_en),
        .command_was_sent             (command_was_sent),
        .error_communication_timed_out(error_communication_timed_out),
        .the_command                  (the_command),
        .send_command                 (send_command),
        .MouseX                       (MouseX),
        .MouseY                       (MouseY),
        .MouseS                       (MouseS),
        .LeftBtn                      (LeftBtn),
        .RightBtn                     (RightBtn),
        .pkt_valid                    (pkt_valid),
        .init_done                    (init_done)
    );

    always #5 Clk = ~Clk;

    // Scoreboard: each pkt_valid pulse must match the oldest expected packet.
    always @(negedge Clk) begin
        if (Reset_n && pkt_valid) begin
            exp_t got;
            exp_t want;
            pulses++;
            got = '{x: MouseX, y: MouseY, l: LeftBtn, r: RightBtn};
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pkt: got x=%0d y=%0d l=%0b r=%0b, required no packet",
                         MouseX, MouseY, LeftBtn, RightBtn);
            end else begin
                want = sb.pop_front();
                if (got !== want) begin
                    errors++;
                    $display("FAIL pkt_update: got x=%0d y=%0d l=%0b r=%0b, required x=%0d y=%0d l=%0b r=%0b",
                             got.x, got.y, got.l, got.r, want.x, want.y, want.l, want.r);
                end
            end
        end
    end

    function automatic int clampv(input int v, input int lim);
        if (v < 0) return 0;
        if (v > lim - 1) return lim - 1;
        return v;
    endfunction

    function automatic int scale(input int d);
`ifdef MOUSE_ACCEL_EN
        if (d >= 8 || d <= -8) return d * 2;
`endif
        return d;
    endfunction

    // Caller is always at a negedge; back-to-back calls with gap 0 give consecutive strobes.
    task automatic send_byte(input logic [7:0] b, input int gap);
        received_data    = b;
        received_data_en = 1'b1;
        @(negedge Clk);
        received_data_en = 1'b0;
        repeat (gap) @(negedge Clk);
    endtask

    task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                            input int gap);
        int dx;
        int dy;
        exp_t e;
        dx = b0[4] ? int'(b1) - 256 : int'(b1);
        dy = b0[5] ? int'(b2) - 256 : int'(b2);
        if (b0[7:6] == 2'b00) begin
            mx = clampv(mx + scale(dx), 640);
            my = clampv(my - scale(dy), 480);
        end
        e = '{x: 10'(mx), y: 10'(my), l: b0[0], r: b0[1]};
        sb.push_back(e);
        pushed++;
        send_byte(b0, gap);
        send_byte(b1, gap);
        send_byte(b2, gap);
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge Clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d packets outstanding, required 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge Clk);
        checks++;
        if ({MouseX, MouseY, MouseS} !== {10'd320, 10'd240, 10'd4}) begin
            errors++;
            $display("FAIL reset_pos: got x=%0d y=%0d s=%0d, required 320 240 4", MouseX, MouseY, MouseS);
        end
        checks++;
        if ({LeftBtn, RightBtn, pkt_valid, init_done, send_command} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b, required 00000",
                     {LeftBtn, RightBtn, pkt_valid, init_done, send_command});
        end
        checks++;
        if (the_command !== 8'hF4) begin
            errors++;
            $display("FAIL reset_cmd: got %h, required f4", the_command);
        end
        Reset_n = 1'b1;
        repeat (3) @(negedge Clk);
        checks++;
        if (send_command !== 1'b1 || the_command !== 8'hF4) begin
            errors++;
            $display("FAIL send_req: got send=%b cmd=%h, required 1 f4", send_command, the_command);
        end
    endtask

    task automatic test_error_retry();
        error_communication_timed_out = 1'b1;
        @(negedge Clk);
        error_communication_timed_out = 1'b0;
        checks++;
        if (send_command !== 1'b0) begin
            errors++;
            $display("FAIL err_drop: got send=%b, required 0", send_command);
        end
        @(negedge Clk);
        checks++;
        if (send_command !== 1'b1) begin
            errors++;
            $display("FAIL err_reassert: got send=%b, required 1", send_command);
        end
    endtask

    task automatic test_init();
        bit seen;
        command_was_sent = 1'b1;
        @(negedge Clk);
        command_was_sent = 1'b0;
        checks++;
        if (send_command !== 1'b0) begin
            errors++;
            $display("FAIL sent_drop: got send=%b, required 0", send_command);
        end
        send_byte(8'hAA, 1);
        checks++;
        if (init_done !== 1'b0) begin
            errors++;
            $display("FAIL non_ack: got init_done=%b, required 0", init_done);
        end
        seen = 1'b0;
        for (int i = 0; i < 2 * ACK_TO && !seen; i++) begin
            @(negedge Clk);
            seen = (send_command === 1'b1);
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL ack_timeout: got no resend within %0d cycles, required resend", 2 * ACK_TO);
        end
        command_was_sent = 1'b1;
        @(negedge Clk);
        command_was_sent = 1'b0;
        send_byte(8'hFA, 0);
        checks++;
        if (init_done !== 1'b1 || MouseX !== 10'd320 || MouseY !== 10'd240) begin
            errors++;
            $display("FAIL init: got init_done=%b x=%0d y=%0d, required 1 320 240", init_done, MouseX, MouseY);
        end
    endtask

    task automatic test_move();
        send_pkt(8'h08, 8'h05, 8'h03, 2);
        wait_drain("move");
        checks++;
        if (MouseX !== 10'd325 || MouseY !== 10'd237) begin
            errors++;
            $display("FAIL move_abs: got x=%0d y=%0d, required 325 237", MouseX, MouseY);
        end
    endtask

    task automatic test_clamp();
        send_pkt(8'h18, 8'h00, 8'h00, 2);
        send_pkt(8'h18, 8'hC0, 8'h00, 2);
        send_pkt(8'h28, 8'h00, 8'h5D, 2);
        send_pkt(8'h19, 8'hF6, 8'h00, 2);
        wait_drain("clamp_x");
        checks++;
        if (MouseX !== 10'd0 || LeftBtn !== 1'b1) begin
            errors++;
            $display("FAIL clamp_x0: got x=%0d l=%b, required 0 1", MouseX, LeftBtn);
        end
        send_pkt(8'h28, 8'h00, 8'h80, 2);
        wait_drain("clamp_y");
        checks++;
        if (MouseY !== 10'd479) begin
            errors++;
            $display("FAIL clamp_y479: got y=%0d, required 479", MouseY);
        end
        send_pkt(8'h08, 8'hFF, 8'h81, 2);
        send_pkt(8'h08, 8'hFF, 8'h81, 2);
        send_pkt(8'h08, 8'hFF, 8'h81, 2);
        wait_drain("clamp_hi");
    endtask

    task automatic test_sync_discard();
        send_byte(8'h00, 2);
        send_pkt(8'h08, 8'h01, 8'h01, 2);
        wait_drain("sync");
    endtask

    task automatic test_pkt_timeout();
        send_byte(8'h08, 2);
        send_byte(8'h01, 2);
        repeat (PKT_TO + 30) @(negedge Clk);
        send_pkt(8'h08, 8'h02, 8'h00, 2);
        wait_drain("pkt_timeout");
    endtask

    task automatic test_overflow();
        int x0;
        x0 = mx;
        send_pkt(8'h4A, 8'h10, 8'h00, 2);
        wait_drain("overflow");
        checks++;
        if (int'(MouseX) != x0 || RightBtn !== 1'b1) begin
            errors++;
            $display("FAIL overflow_hold: got x=%0d r=%b, required %0d 1", MouseX, RightBtn, x0);
        end
    endtask

    task automatic test_accel();
        int x0;
        int step;
        x0 = int'(MouseX);
`ifdef MOUSE_ACCEL_EN
        step = 20;
`else
        step = 10;
`endif
        send_pkt(8'h08, 8'h0A, 8'h00, 2);
        wait_drain("accel");
        checks++;
        if (int'(MouseX) != clampv(x0 + step, 640)) begin
            errors++;
            $display("FAIL accel_step: got x=%0d, required %0d", MouseX, clampv(x0 + step, 640));
        end
    endtask

    task automatic test_back_to_back();
        send_pkt(8'h08, 8'h07, 8'hF9, 0);
        send_pkt(8'h39, 8'hF9, 8'h07, 0);
        send_pkt(8'h0B, 8'h03, 8'h04, 0);
        wait_drain("b2b");
        checks++;
        if (pulses != pushed || MouseS !== 10'd4) begin
            errors++;
            $display("FAIL pulse_count: got pulses=%0d s=%0d, required %0d 4", pulses, MouseS, pushed);
        end
    endtask

    initial begin
        test_reset();
        test_error_retry();
        test_init();
        test_move();
        test_clamp();
        test_sync_discard();
        test_pkt_timeout();
        test_overflow();
        test_accel();
        test_back_to_back();
        repeat (5) @(negedge Clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
